// File: rtl/tile_plotter_if.sv
// Host/ROM-side bus of the tile plotter: start handshake, base coordinate,
// sprite ROM address/data and the pixel plot stream to the VGA adapter.
interface tile_plotter_if #(
  parameter int ADDR_W  = 8,
  parameter int COLOR_W = 6
);
  logic               start;
  logic [7:0]         x_in;
  logic [6:0]         y_in;
  logic [1:0]         sel_in;
  logic [ADDR_W-1:0]  rom_addr;
  logic [1:0]         rom_sel;
  logic [COLOR_W-1:0] rom_data;
  logic               busy;
  logic               done;
  logic               plot;
  logic [7:0]         x_out;
  logic [6:0]         y_out;
  logic [COLOR_W-1:0] color;

  modport master (
    output start, x_in, y_in, sel_in, rom_data,
    input  rom_addr, rom_sel, busy, done, plot, x_out, y_out, color
  );

  modport slave (
    input  start, x_in, y_in, sel_in, rom_data,
    output rom_addr, rom_sel, busy, done, plot, x_out, y_out, color
  );
endinterface

// File: rtl/tile_plotter.sv
// Tile blitter: walks a TILE_W x TILE_H tile row-major, addresses the sprite
// ROM and emits one plot strobe per pixel aligned to the ROM read latency.
module tile_plotter #(
  parameter int                 TILE_W     = 12,
  parameter int                 TILE_H     = 12,
  parameter int                 ADDR_W     = 8,
  parameter int                 COLOR_W    = 6,
  parameter int                 ROM_LAT    = 1,
  parameter int                 TRANSP_EN  = 0,
  parameter logic [COLOR_W-1:0] TRANSP_KEY = '0
) (
  input  logic         clock,
  input  logic         resetn,
  tile_plotter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [4:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [2:0] drain_q, drain_d;
  logic [7:0] xb_q;
  logic [6:0] yb_q;
  logic [1:0] sel_q;

  logic       vld_q [ROM_LAT];
  logic [7:0] px_q  [ROM_LAT];
  logic [6:0] py_q  [ROM_LAT];

  logic              accept;
  logic              issue;
  logic              col_last;
  logic              last_px;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        px_new;
  logic [6:0]        py_new;

  assign accept   = (state_q == S_IDLE) && bus.start;
  assign issue    = (state_q == S_RUN);
  assign col_last = (col_q == 5'(TILE_W - 1));
  assign last_px  = col_last && (row_q == 5'(TILE_H - 1));
  assign addr     = ADDR_W'(row_q) * ADDR_W'(TILE_W) + ADDR_W'(col_q);
  assign px_new   = xb_q + 8'(col_q);
  assign py_new   = yb_q + 7'(row_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        if (col_last) begin
          col_d = '0;
          row_d = row_q + 5'd1;
        end else begin
          col_d = col_q + 5'd1;
        end
        if (last_px) begin
          state_d = S_DRAIN;
          row_d   = '0;
          drain_d = 3'(ROM_LAT);
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - 3'd1;
        if (drain_q == 3'd1) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The coordinate pipeline shifts every cycle; only the valid bit marks real pixels.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      sel_q   <= '0;
      for (int unsigned i = 0; i < unsigned'(ROM_LAT); i++) begin
        vld_q[i] <= 1'b0;
        px_q[i]  <= '0;
        py_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      if (accept) begin
        xb_q  <= bus.x_in;
        yb_q  <= bus.y_in;
        sel_q <= bus.sel_in;
      end
      vld_q[0] <= issue;
      px_q[0]  <= px_new;
      py_q[0]  <= py_new;
      for (int unsigned i = 1; i < unsigned'(ROM_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        px_q[i]  <= px_q[i-1];
        py_q[i]  <= py_q[i-1];
      end
    end
  end

  assign bus.rom_addr = issue ? addr : '0;
  assign bus.rom_sel  = sel_q;
  assign bus.busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.plot     = vld_q[ROM_LAT-1] &&
                        !((TRANSP_EN != 0) && (bus.rom_data == TRANSP_KEY));
  assign bus.x_out    = px_q[ROM_LAT-1];
  assign bus.y_out    = py_q[ROM_LAT-1];
  assign bus.color    = bus.rom_data;

endmodule

// File: tb/tb_tile_plotter.sv
// Directed bench for tile_plotter: default 12x12, a 6x6 latency-3 variant and
// a transparent-key variant, each fed by a small behavioural sprite ROM.
module tb_tile_plotter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start_a, start_b, start_c;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [1:0] sel_in;

  int vectors = 0;
  int errs    = 0;

  always #5 clock = ~clock;

  tile_plotter_if #(.ADDR_W(8), .COLOR_W(6)) ia ();
  tile_plotter_if #(.ADDR_W(8), .COLOR_W(6)) ib ();
  tile_plotter_if #(.ADDR_W(8), .COLOR_W(6)) ic ();

  tile_plotter ua (.clock(clock), .resetn(resetn), .bus(ia));
  tile_plotter #(.TILE_W(6), .TILE_H(6), .ROM_LAT(3)) ub (.clock(clock), .resetn(resetn), .bus(ib));
  tile_plotter #(.TRANSP_EN(1), .TRANSP_KEY(6'h00)) uc (.clock(clock), .resetn(resetn), .bus(ic));

  assign ia.start = start_a;  assign ib.start = start_b;  assign ic.start = start_c;
  assign ia.x_in = x_in;      assign ib.x_in = x_in;      assign ic.x_in = x_in;
  assign ia.y_in = y_in;      assign ib.y_in = y_in;      assign ic.y_in = y_in;
  assign ia.sel_in = sel_in;  assign ib.sel_in = sel_in;  assign ic.sel_in = sel_in;

  // Sprite ROM contents: DUT 2 returns the key (0) on every even address.
  function automatic logic [5:0] romf(input int d, input logic [7:0] a);
    if (d == 2) return a[0] ? a[5:0] : 6'h00;
    return a[5:0] ^ 6'h15;
  endfunction

  logic [7:0] pa [4];
  logic [7:0] pb [4];
  logic [7:0] pc [4];
  always @(posedge clock) begin
    pa[0] <= ia.rom_addr;
    pb[0] <= ib.rom_addr;
    pc[0] <= ic.rom_addr;
    for (int i = 1; i < 4; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
      pc[i] <= pc[i-1];
    end
  end
  assign ia.rom_data = romf(0, pa[0]);
  assign ib.rom_data = romf(1, pb[2]);
  assign ic.rom_data = romf(2, pc[0]);

  int s_busy, s_done, s_plot, s_addr, s_x, s_y, s_col, s_sel;

  task automatic sample(input int d);
    case (d)
      0: begin
        s_busy = ia.busy; s_done = ia.done; s_plot = ia.plot; s_addr = ia.rom_addr;
        s_x = ia.x_out; s_y = ia.y_out; s_col = ia.color; s_sel = ia.rom_sel;
      end
      1: begin
        s_busy = ib.busy; s_done = ib.done; s_plot = ib.plot; s_addr = ib.rom_addr;
        s_x = ib.x_out; s_y = ib.y_out; s_col = ib.color; s_sel = ib.rom_sel;
      end
      default: begin
        s_busy = ic.busy; s_done = ic.done; s_plot = ic.plot; s_addr = ic.rom_addr;
        s_x = ic.x_out; s_y = ic.y_out; s_col = ic.color; s_sel = ic.rom_sel;
      end
    endcase
  endtask

  task automatic set_start(input int d, input logic v);
    start_a = (d == 0) ? v : 1'b0;
    start_b = (d == 1) ? v : 1'b0;
    start_c = (d == 2) ? v : 1'b0;
  endtask

  task automatic chk(input string nm, input int cyc, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s @cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  // Draws one tile on DUT d and checks every cycle from 1 to P+LAT+2.
  // poke1/poke2 are cycles in which a conflicting start is driven.
  task automatic draw(input int d, input int W, input int H, input int LAT, input bit tr,
                      input logic [7:0] x, input logic [6:0] y, input logic [1:0] s,
                      input int poke1, input int poke2,
                      output int np, output int fx, output int fy, output int lx, output int ly);
    int P, k, last_c;
    bit inwin, ep;
    P = W * H;
    last_c = P + LAT + 2;
    np = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    @(negedge clock);
    x_in = x; y_in = y; sel_in = s;
    set_start(d, 1'b1);
    @(negedge clock);
    set_start(d, 1'b0);
    for (int c = 1; c <= last_c; c++) begin
      sample(d);
      k     = c - 1 - LAT;
      inwin = (c >= 1 + LAT) && (c <= P + LAT);
      ep    = inwin && !(tr && (k % 2 == 0));
      chk("busy", c, s_busy, (c <= P + LAT) ? 1 : 0);
      chk("done", c, s_done, (c == P + LAT + 1) ? 1 : 0);
      chk("plot", c, s_plot, ep ? 1 : 0);
      if (c <= P) chk("rom_addr", c, s_addr, c - 1);
      if (inwin) begin
        chk("x_out", c, s_x, (x + k % W) % 256);
        chk("y_out", c, s_y, (y + k / W) % 128);
        chk("color", c, s_col, romf(d, 8'(k)));
        if (k == 0)     begin fx = s_x; fy = s_y; end
        if (k == P - 1) begin lx = s_x; ly = s_y; end
      end
      np += s_plot;
      if (c < last_c) begin
        if (c == poke1 || c == poke2) begin
          x_in = 8'd99; y_in = 7'd99; sel_in = ~s;
          set_start(d, 1'b1);
        end else begin
          x_in = x; y_in = y; sel_in = s;
          set_start(d, 1'b0);
        end
        @(negedge clock);
      end
    end
    set_start(d, 1'b0);
    chk("rom_sel", last_c, s_sel, s);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] sel;
    int fx, fy, lx, ly, np;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int np, fx, fy, lx, ly;
    tbl[0] = '{x: 8'd10,  y: 7'd20,  sel: 2'd2, fx: 10,  fy: 20,  lx: 21,  ly: 31,  np: 144};
    tbl[1] = '{x: 8'd250, y: 7'd125, sel: 2'd1, fx: 250, fy: 125, lx: 5,   ly: 8,   np: 144};
    tbl[2] = '{x: 8'd0,   y: 7'd0,   sel: 2'd3, fx: 0,   fy: 0,   lx: 11,  ly: 11,  np: 144};
    tbl[3] = '{x: 8'd148, y: 7'd108, sel: 2'd0, fx: 148, fy: 108, lx: 159, ly: 119, np: 144};

    resetn = 1'b0;
    set_start(0, 1'b0);
    x_in = '0; y_in = '0; sel_in = '0;
    repeat (3) @(negedge clock);
    sample(0);
    chk("rst_busy", 0, s_busy, 0);
    chk("rst_done", 0, s_done, 0);
    chk("rst_plot", 0, s_plot, 0);
    chk("rst_addr", 0, s_addr, 0);
    chk("rst_xy", 0, s_x + s_y, 0);
    chk("rst_sel", 0, s_sel, 0);
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      draw(0, 12, 12, 1, 1'b0, tbl[i].x, tbl[i].y, tbl[i].sel, -1, -1, np, fx, fy, lx, ly);
      chk("tbl_nplots", i, np, tbl[i].np);
      chk("tbl_first_x", i, fx, tbl[i].fx);
      chk("tbl_first_y", i, fy, tbl[i].fy);
      chk("tbl_last_x", i, lx, tbl[i].lx);
      chk("tbl_last_y", i, ly, tbl[i].ly);
    end

    // 6x6 tile with three-cycle ROM latency.
    draw(1, 6, 6, 3, 1'b0, 8'd5, 7'd5, 2'd1, -1, -1, np, fx, fy, lx, ly);
    chk("lat3_nplots", 0, np, 36);
    chk("lat3_last_x", 0, lx, 10);

    // Transparent key suppresses the even-address pixels.
    draw(2, 12, 12, 1, 1'b1, 8'd10, 7'd20, 2'd2, -1, -1, np, fx, fy, lx, ly);
    chk("transp_nplots", 0, np, 72);

    // Starts during RUN and in the done cycle must be ignored.
    draw(0, 12, 12, 1, 1'b0, 8'd30, 7'd40, 2'd1, 50, 146, np, fx, fy, lx, ly);
    chk("ignore_nplots", 0, np, 144);
    repeat (3) @(negedge clock);
    sample(0);
    chk("ignore_idle_busy", 0, s_busy, 0);
    chk("ignore_idle_sel", 0, s_sel, 1);

    // Reset in the middle of a draw.
    @(negedge clock);
    x_in = 8'd10; y_in = 7'd20; sel_in = 2'd3;
    set_start(0, 1'b1);
    @(negedge clock);
    set_start(0, 1'b0);
    repeat (69) @(negedge clock);
    sample(0);
    chk("pre_rst_busy", 70, s_busy, 1);
    resetn = 1'b0;
    @(negedge clock);
    sample(0);
    chk("abort_plot", 71, s_plot, 0);
    chk("abort_busy", 71, s_busy, 0);
    chk("abort_done", 71, s_done, 0);
    chk("abort_addr", 71, s_addr, 0);
    chk("abort_xy", 71, s_x + s_y, 0);
    chk("abort_sel", 71, s_sel, 0);
    resetn = 1'b1;
    @(negedge clock);
    sample(0);
    chk("abort_stays_idle", 72, s_busy, 0);
    draw(0, 12, 12, 1, 1'b0, 8'd10, 7'd20, 2'd2, -1, -1, np, fx, fy, lx, ly);
    chk("redraw_nplots", 0, np, 144);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/tile_plotter.md
Name: tile_plotter

Overview:
- Parametrised tile blitter for the VGA adapter path (160x120, 6-bit colour).
- On a start pulse it latches a base coordinate and a sprite select, then walks every pixel of a TILE_W x TILE_H tile in row-major order.
- It issues addresses to an external sprite ROM bank and emits one plot strobe per pixel, aligned to the ROM's read latency.
- Adds to the previous plotter: configurable tile size, ROM latency, optional transparent colour key, and a start/busy/done handshake.

Parameters:
- TILE_W, 12, tile width in pixels (1..16).
- TILE_H, 12, tile height in pixels (1..16).
- ADDR_W, 8, ROM address width; must satisfy 2^ADDR_W >= TILE_W*TILE_H.
- COLOR_W, 6, colour width.
- ROM_LAT, 1, ROM read latency in clock cycles (1..4).
- TRANSP_EN, 0, 1 = suppress plot for pixels equal to TRANSP_KEY.
- TRANSP_KEY, 6'h00, transparent colour value.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request a tile draw; sampled only in IDLE.
- x_in  in  8  tile base x, latched on accepted start.
- y_in  in  7  tile base y, latched on accepted start.
- sel_in  in  2  sprite select (0 empty, 1 cursor, 2 black, 3 white), latched on accepted start.
- rom_addr  out  ADDR_W  pixel address to the sprite ROM bank.
- rom_sel  out  2  latched select to the ROM bank mux.
- rom_data  in  COLOR_W  ROM output, valid ROM_LAT cycles after rom_addr.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at completion.
- plot  out  1  write strobe to the VGA adapter.
- x_out  out  8  pixel x.
- y_out  out  7  pixel y.
- color  out  COLOR_W  pixel colour; equals rom_data.

Behaviour:
- Reset (resetn=0 at a clock edge), from any state, including mid-draw:
  - state goes to IDLE; col, row, latched x/y/sel and the valid/coordinate pipeline are cleared.
  - busy=0, done=0, plot=0, x_out=0, y_out=0, rom_addr=0, rom_sel=0.
  - The aborted tile is not resumed.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 at an edge: latch x_in, y_in, sel_in; col=0, row=0; go to RUN.
  - start is ignored in RUN, DRAIN and DONE (no queuing).
- RUN:
  - rom_addr = row*TILE_W + col (combinational from counters).
  - Each cycle col increments. At col==TILE_W-1, col wraps to 0 and row increments.
  - After issuing address TILE_W*TILE_H-1, go to DRAIN with DRAIN count = ROM_LAT.
- DRAIN: hold for ROM_LAT cycles, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. A start in that cycle is ignored.
- Pipeline:
  - A ROM_LAT-deep shift register carries valid, x_base+col and y_base+row alongside each issued address.
  - plot, x_out and y_out are the pipeline tail, so each is aligned with rom_data for that address.
- Timing, with start sampled at the end of cycle 0 and P=TILE_W*TILE_H:
  - address k is issued in cycle k+1;
  - pixel k is plotted in cycle k+1+ROM_LAT;
  - the last plot is in cycle P+ROM_LAT;
  - done is in cycle P+ROM_LAT+1.
- Transparency: if TRANSP_EN=1 and rom_data==TRANSP_KEY in a valid cycle, plot=0. x_out and y_out still advance.
- Arithmetic: x_out = (x_base+col) mod 256 and y_out = (y_base+row) mod 128. Coordinates wrap by truncation and are not clipped.
- rom_sel holds the latched select from start until the next accepted start.

Test Plan:
1. Defaults; start with x_in=10, y_in=20, sel_in=2 -> 144 plot cycles in cycles 2..145; first pixel (10,20); pixel 12 at (10,21); last pixel (21,31); rom_addr 0..143; done only in cycle 146; busy high in cycles 1..145.
2. TILE_W=6, TILE_H=6, ROM_LAT=3 -> 36 plots in cycles 4..39; done in cycle 40; plot never high during DRAIN-only cycles after cycle 39.
3. TRANSP_EN=1, key 6'h00, ROM model returning 0 on even addresses -> exactly 72 plot pulses (defaults); x_out/y_out sequence unchanged.
4. x_in=250, y_in=125 -> x_out wraps to 0 at col 6; y_out wraps to 0 at row 3.
5. start re-asserted at cycle 50 and in the done cycle -> ignored; exactly one tile drawn; rom_sel unchanged.
6. resetn=0 at cycle 70 mid-draw -> next cycle plot=0, busy=0, done=0, state IDLE; a new start draws a full 144-pixel tile from address 0.
